// File: rtl/vga_avalon_fifo_if.sv
// Bus bundle between the Avalon-MM master and vga_avalon_fifo, including the
// plot-side outputs towards vga_adapter.
// Ports: address/read/readdata/write/writedata/waitrequest (Avalon side),
//        vga_x/vga_y/vga_colour/vga_plot (plot side).
interface vga_avalon_fifo_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic [3:0]     address;
  logic           read;
  logic [31:0]    readdata;
  logic           write;
  logic [31:0]    writedata;
  logic           waitrequest;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest, vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_avalon_fifo.sv
// Avalon-MM slave buffering pixel/fill commands in a FIFO, drained by a plot engine.
// Latency: write accepted at edge E plots during the cycle after edge E+1; reads 1 cycle.
// Backpressure: waitrequest (combinational) stalls PIXEL/FILL writes while the FIFO is full.
// Ports: clk, reset_n (async active-low), bus (slave modport: Avalon + plot outputs).
module vga_avalon_fifo #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int C_W        = 3,
  parameter int X_MAX      = 160,
  parameter int Y_MAX      = 120,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_avalon_fifo_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + C_W + X_W + Y_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  // Write field decode
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic [C_W-1:0] wr_c;
  logic           pixel_ok;
  logic           wr_pix, wr_fill, wr_cmd, full, push, pop, busy;

  assign wr_x     = bus.writedata[8+X_W-1:8];
  assign wr_y     = bus.writedata[Y_W-1:0];
  assign wr_c     = bus.writedata[16+C_W-1:16];
  assign pixel_ok = (32'(wr_x) < 32'(X_MAX)) && (32'(wr_y) < 32'(Y_MAX));
  assign wr_pix   = bus.write && (bus.address == 4'd0);
  assign wr_fill  = bus.write && (bus.address == 4'd1);
  // An out-of-range pixel is dropped immediately, so it never stalls.
  assign wr_cmd   = (wr_pix && pixel_ok) || wr_fill;

  // FIFO state
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [EW-1:0] head;

  // Engine / register state
  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic           plot_q, plot_d;
  logic           drop_q, drop_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [31:0]    readdata_q, readdata_d;
  logic [31:0]    status;

  // Full is taken from registered occupancy only, so a same-cycle pop
  // never lifts a stall.
  assign full            = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push            = wr_cmd && !full;
  assign pop             = (state_q == S_IDLE) && (count_q != '0);
  assign head            = mem_q[rd_ptr_q];
  assign busy            = (count_q != '0) || (state_q != S_IDLE);
  assign bus.waitrequest = wr_cmd && full;

  assign status = {16'd0, 8'(count_q), 5'd0, drop_q, full, busy};

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Entry layout: {is_fill, colour, x, y}
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          colour_d = head[X_W+Y_W +: C_W];
          plot_d   = 1'b1;
          if (head[EW-1]) begin
            state_d = S_FILL;
            x_d     = '0;
            y_d     = '0;
          end else begin
            x_d = head[Y_W +: X_W];
            y_d = head[0 +: Y_W];
          end
        end
      end
      S_FILL: begin
        // The registered outputs already show the current pixel; compute the next.
        if (x_q == X_W'(X_MAX-1) && y_q == Y_W'(Y_MAX-1)) begin
          state_d = S_IDLE;
        end else begin
          plot_d = 1'b1;
          if (x_q == X_W'(X_MAX-1)) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (bus.write && bus.address == 4'd2) drop_d = 1'b0;
    if (wr_pix && !pixel_ok)              drop_d = 1'b1;

    // Clear has priority over a coincident increment.
    cnt_d = cnt_q + 32'(plot_q);
    if (bus.write && bus.address == 4'd3) cnt_d = '0;

    readdata_d = readdata_q;
    if (bus.read) begin
      case (bus.address)
        4'd2:    readdata_d = status;
        4'd3:    readdata_d = cnt_q;
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_fill, wr_c, wr_x, wr_y};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata   = readdata_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;

endmodule

// File: tb/tb_vga_avalon_fifo.sv
// Directed bench for vga_avalon_fifo: reset, single pixel, bursts, fill,
// back-pressure, range drop and mid-fill reset.
module tb_vga_avalon_fifo;

  logic clk;
  logic reset_n;

  vga_avalon_fifo_if #(.X_W(8), .Y_W(7), .C_W(3)) bus ();

  vga_avalon_fifo #(
    .X_W(8), .Y_W(7), .C_W(3), .X_MAX(160), .Y_MAX(120), .FIFO_DEPTH(16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } plot_t;

  plot_t plots [$];
  int    cyc;
  int    acc_cyc;
  int    n_chk;
  int    n_fail;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.vga_plot === 1'b1)
      plots.push_back('{int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour), cyc});
  end

  function automatic logic [31:0] pix(input int x, input int y, input int c);
    return (32'(c) << 16) | (32'(x) << 8) | 32'(y);
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, output int stall);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    stall         = 0;
    #1;
    while (bus.waitrequest === 1'b1 && stall < 40000) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (stall >= 40000) begin
      n_chk++; n_fail++;
      $display("FAIL write_timeout: waitrequest still 1 after %0d cycles, required 0", stall);
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic wait_idle(input int bound);
    logic [31:0] s;
    int i;
    i = 0;
    do begin
      do_read(4'd2, s);
      i++;
    end while (s[0] !== 1'b0 && i < bound);
    if (s[0] !== 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: STATUS=%h after %0d polls, required busy=0", s, i);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.vga_plot !== 1'b0) begin
      n_fail++; $display("FAIL reset_plot: got %b, required 0", bus.vga_plot);
    end
    n_chk++;
    if (bus.waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL reset_waitrequest: got %b, required 0", bus.waitrequest);
    end
    reset_n = 1'b1;
    do_read(4'd2, d);
    n_chk++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL reset_status: got %h, required 0", d);
    end
    do_read(4'd3, d);
    n_chk++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %h, required 0", d);
    end
  endtask

  task automatic test_single_pixel();
    logic [31:0] d;
    int st;
    plots.delete();
    do_write(4'd0, pix(10, 20, 5), st);
    wait_idle(50);
    n_chk++;
    if (plots.size() != 1) begin
      n_fail++; $display("FAIL single_plot_count: got %0d, required 1", plots.size());
    end else begin
      n_chk++;
      if (plots[0].x != 10 || plots[0].y != 20 || plots[0].c != 5) begin
        n_fail++;
        $display("FAIL single_plot_value: got (%0d,%0d,%0d), required (10,20,5)",
                 plots[0].x, plots[0].y, plots[0].c);
      end
      n_chk++;
      if (plots[0].cyc != acc_cyc + 1) begin
        n_fail++;
        $display("FAIL single_latency: plot after edge %0d, required edge %0d",
                 plots[0].cyc, acc_cyc + 1);
      end
    end
    do_read(4'd3, d);
    n_chk++;
    if (d !== 32'd1) begin
      n_fail++; $display("FAIL single_count: got %0d, required 1", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int st;
    plots.delete();
    for (int i = 0; i < 5; i++) do_write(4'd0, pix(i, 0, i + 1), st);
    wait_idle(50);
    n_chk++;
    if (plots.size() != 5) begin
      n_fail++; $display("FAIL b2b_plot_count: got %0d, required 5", plots.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (plots[i].x != i || plots[i].y != 0 || plots[i].c != i + 1 ||
            plots[i].cyc != plots[0].cyc + i) begin
          n_fail++;
          $display("FAIL b2b_plot_%0d: got (%0d,%0d,%0d)@%0d, required (%0d,0,%0d)@%0d",
                   i, plots[i].x, plots[i].y, plots[i].c, plots[i].cyc,
                   i, i + 1, plots[0].cyc + i);
        end
      end
    end
    do_read(4'd2, d);
    n_chk++;
    if (d[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy: got %b, required 0", d[0]);
    end
  endtask

  task automatic test_fill();
    logic [31:0] d;
    int st;
    do_write(4'd3, 32'd0, st);
    plots.delete();
    do_write(4'd1, pix(0, 0, 3), st);
    wait_idle(20000);
    n_chk++;
    if (plots.size() != 19200) begin
      n_fail++; $display("FAIL fill_plot_count: got %0d, required 19200", plots.size());
    end else begin
      n_chk++;
      if (plots[0].x != 0 || plots[0].y != 0 || plots[0].c != 3) begin
        n_fail++;
        $display("FAIL fill_first: got (%0d,%0d,%0d), required (0,0,3)",
                 plots[0].x, plots[0].y, plots[0].c);
      end
      n_chk++;
      if (plots[160].x != 0 || plots[160].y != 1) begin
        n_fail++;
        $display("FAIL fill_wrap: got (%0d,%0d), required (0,1)", plots[160].x, plots[160].y);
      end
      n_chk++;
      if (plots[19199].x != 159 || plots[19199].y != 119 || plots[19199].c != 3) begin
        n_fail++;
        $display("FAIL fill_last: got (%0d,%0d,%0d), required (159,119,3)",
                 plots[19199].x, plots[19199].y, plots[19199].c);
      end
      n_chk++;
      if (plots[19199].cyc - plots[0].cyc != 19199) begin
        n_fail++;
        $display("FAIL fill_contiguous: span %0d cycles, required 19199",
                 plots[19199].cyc - plots[0].cyc);
      end
    end
    do_read(4'd3, d);
    n_chk++;
    if (d !== 32'd19200) begin
      n_fail++; $display("FAIL fill_count: got %0d, required 19200", d);
    end
    do_write(4'd3, 32'd0, st);
    do_read(4'd3, d);
    n_chk++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL count_clear: got %0d, required 0", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int st;
    int base;
    plots.delete();
    do_write(4'd1, pix(0, 0, 2), st);
    for (int i = 0; i < 16; i++) begin
      do_write(4'd0, pix(i, 1, i % 8), st);
      n_chk++;
      if (st != 0) begin
        n_fail++; $display("FAIL bp_early_stall_%0d: stalled %0d cycles, required 0", i, st);
      end
    end
    do_read(4'd2, d);
    n_chk++;
    if (d[1] !== 1'b1 || d[15:8] !== 8'd16 || d[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_status_full: got %h, required full=1 occ=16 busy=1", d);
    end
    do_write(4'd0, pix(16, 1, 0), st);
    n_chk++;
    if (st < 18000) begin
      n_fail++; $display("FAIL bp_stall_len: stalled %0d cycles, required >= 18000", st);
    end
    wait_idle(200);
    n_chk++;
    if (plots.size() != 19217) begin
      n_fail++; $display("FAIL bp_plot_count: got %0d, required 19217", plots.size());
    end else begin
      n_chk++;
      if (plots[19199].x != 159 || plots[19199].y != 119 || plots[19199].c != 2) begin
        n_fail++;
        $display("FAIL bp_fill_last: got (%0d,%0d,%0d), required (159,119,2)",
                 plots[19199].x, plots[19199].y, plots[19199].c);
      end
      base = 19200;
      for (int i = 0; i < 17; i++) begin
        n_chk++;
        if (plots[base+i].x != i || plots[base+i].y != 1 || plots[base+i].c != i % 8) begin
          n_fail++;
          $display("FAIL bp_pixel_%0d: got (%0d,%0d,%0d), required (%0d,1,%0d)",
                   i, plots[base+i].x, plots[base+i].y, plots[base+i].c, i, i % 8);
        end
      end
    end
  endtask

  task automatic test_drop();
    logic [31:0] d;
    int st;
    plots.delete();
    do_write(4'd0, pix(160, 5, 1), st);
    n_chk++;
    if (st != 0) begin
      n_fail++; $display("FAIL drop_stall: stalled %0d cycles, required 0", st);
    end
    do_write(4'd0, pix(5, 120, 1), st);
    repeat (5) @(negedge clk);
    n_chk++;
    if (plots.size() != 0) begin
      n_fail++; $display("FAIL drop_plot: got %0d plots, required 0", plots.size());
    end
    do_read(4'd2, d);
    n_chk++;
    if (d !== 32'h0000_0004) begin
      n_fail++; $display("FAIL drop_status: got %h, required 00000004", d);
    end
    do_write(4'd2, 32'd0, st);
    do_read(4'd2, d);
    n_chk++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL drop_clear: got %h, required 0", d);
    end
  endtask

  task automatic test_reset_midfill();
    logic [31:0] d;
    int st;
    int i;
    int n0;
    plots.delete();
    do_write(4'd1, pix(0, 0, 6), st);
    do_write(4'd0, pix(7, 7, 1), st);
    i = 0;
    while (plots.size() < 500 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    n_chk++;
    if (plots.size() < 500) begin
      n_fail++; $display("FAIL midfill_progress: got %0d plots, required 500", plots.size());
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (bus.vga_plot !== 1'b0 || bus.vga_x !== 8'd0) begin
      n_fail++;
      $display("FAIL midfill_async: plot=%b x=%0d, required plot=0 x=0", bus.vga_plot, bus.vga_x);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n0 = plots.size();
    repeat (40) @(negedge clk);
    n_chk++;
    if (plots.size() != n0) begin
      n_fail++; $display("FAIL midfill_resume: got %0d new plots, required 0", plots.size() - n0);
    end
    do_read(4'd2, d);
    n_chk++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL midfill_status: got %h, required 0", d);
    end
    do_read(4'd3, d);
    n_chk++;
    if (d !== 32'd0) begin
      n_fail++; $display("FAIL midfill_count: got %0d, required 0", d);
    end
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    cyc           = 0;
    acc_cyc       = 0;
    reset_n       = 1'b0;
    bus.address   = 4'd0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = 32'd0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_fill();
    test_backpressure();
    test_drop();
    test_reset_midfill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_avalon_fifo.md
Name: vga_avalon_fifo

Overview:
Parametrised Avalon-MM slave that accepts pixel and full-screen fill commands, buffers them in an internal command FIFO, and drains them through a plot engine. The engine drives the plot interface of the existing vga_adapter (x, y, colour, plot). It extends the single-pixel vga_avalon with buffering, back-pressure, a fill mode, and readable status and counter registers. It sits between the Nios/Avalon interconnect and vga_adapter.

Parameters:
X_W, 8, x coordinate width (<=8)
Y_W, 7, y coordinate width (<=8)
C_W, 3, colour width (<=8)
X_MAX, 160, screen width in pixels; valid x range is 0..X_MAX-1
Y_MAX, 120, screen height in pixels; valid y range is 0..Y_MAX-1
FIFO_DEPTH, 16, command FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  4  Avalon word address
read  in  1  Avalon read strobe
readdata  out  32  read data, valid 1 cycle after read
write  in  1  Avalon write strobe
writedata  in  32  write data
waitrequest  out  1  write stall
vga_x  out  X_W  plot x
vga_y  out  Y_W  plot y
vga_colour  out  C_W  plot colour
vga_plot  out  1  plot strobe, one pixel per high cycle

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on reset_n.
- Reset values: all outputs 0; FIFO empty; engine in IDLE; all counters and flags 0.
- writedata field layout:
  - y = writedata[Y_W-1:0]
  - x = writedata[8+X_W-1:8]
  - colour = writedata[16+C_W-1:16]
- Register map:
  - 0 PIXEL (W): enqueue a pixel entry.
  - 1 FILL (W): enqueue a fill entry; only the colour field is used.
  - 2 STATUS (R): bit0 busy (FIFO non-empty or engine not IDLE), bit1 full, bit2 sticky drop, bits[15:8] FIFO occupancy. Any write to 2 clears the drop flag.
  - 3 COUNT (R): 32-bit count of plotted pixels, wraps at 2^32. Any write to 3 clears it; if a clear and an increment land on the same cycle, the clear wins.
  - Other addresses: reads return 0, writes are ignored.
- waitrequest is combinational. It is 1 iff write=1, address is 0 or 1, and the FIFO is full; otherwise 0.
  - A stalled write is accepted on the first cycle waitrequest=0.
  - A pop on the same cycle as a stalled write does not lift the stall; waitrequest is computed from the registered full flag.
- PIXEL range check: if x>=X_MAX or y>=Y_MAX, the entry is not enqueued, the drop flag is set, and waitrequest is not asserted.
- Reads: readdata is registered and valid on the cycle after read=1. It holds its value otherwise. Reads have no side effects.
- FIFO entry format: {is_fill, colour, x, y}. It supports a simultaneous push and pop when not full; occupancy is then unchanged.
- Engine FSM:
  - IDLE: if the FIFO is non-empty, pop the head entry.
    - Pixel entry: register x, y and colour, pulse vga_plot for 1 cycle, stay IDLE. Back-to-back pixels give vga_plot=1 every cycle.
    - Fill entry: go to FILL with x=0, y=0.
  - FILL: vga_plot=1 every cycle. x increments each cycle; at X_MAX-1 it wraps to 0 and y increments. After (X_MAX-1, Y_MAX-1), return to IDLE. A fill takes exactly X_MAX*Y_MAX plot cycles. The FIFO is not popped during FILL.
- Latency: a write accepted at edge E, with the engine IDLE and the FIFO empty, produces vga_plot=1 during the cycle after edge E+1.
- COUNT increments on every cycle with vga_plot=1.
- vga_x, vga_y and vga_colour hold their last values while vga_plot=0.
- Reset asserted mid-fill or mid-burst: the FIFO is flushed, the engine goes to IDLE, and vga_plot=0 immediately (asynchronous). No partial resume after reset is released.

Test Plan:
1. Reset, then read STATUS and COUNT -> readdata=0 both; vga_plot=0; waitrequest=0.
2. Write addr0 with x=10, y=20, colour=5 -> vga_plot=1 for exactly 1 cycle with (10,20,5), 2 edges after accept; COUNT reads 1.
3. Five consecutive PIXEL writes (0,0)..(4,0) -> vga_plot high 5 consecutive cycles in order; STATUS bit0 reads 0 after the drain.
4. FILL colour=3 -> 19200 consecutive vga_plot cycles, first (0,0,3), last (159,119,3); COUNT=19200; write addr3 -> COUNT=0.
5. FILL followed immediately by 17 PIXEL writes -> 16 accepted; STATUS bit1=1 and occupancy=16; the 17th sees waitrequest=1 until the fill completes, then is accepted. All 17 pixels then plot in order.
6. PIXEL x=160, y=5 -> no vga_plot, STATUS bit2=1, occupancy unchanged; write addr2 -> bit2=0. Reset asserted at fill pixel 500 -> vga_plot=0 immediately, STATUS=0 after reset is released.
